// File: rtl/gpzda_field_parser_if.sv
// Byte-stream and result bundle between the $GPZDA header comparer, the ZDA
// field parser and its consumer.
interface gpzda_field_parser_if #(parameter int YEAR_W = 14);
    logic              load;
    logic [7:0]        data;
    logic              start;
    logic [4:0]        hour;
    logic [5:0]        minute;
    logic [5:0]        second;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              valid;
    logic              error;
    logic              busy;

    modport master (output load, data, start,
                    input  hour, minute, second, day, month, year, valid, error, busy);
    modport slave  (input  load, data, start,
                    output hour, minute, second, day, month, year, valid, error, busy);
endinterface

// File: rtl/gpzda_field_parser.sv
// Parses ",hhmmss[.f*],dd,mm,yyyy,[-]zz,zz*" after a matched $GPZDA header.
// Define GPZDA_CHECKSUM_EN to also check the two trailing hex checksum chars.
module gpzda_field_parser #(
    parameter int YEAR_W = 14
) (
    input  logic                 clock,
    input  logic                 restart_n,
    gpzda_field_parser_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, SEP, TIME, FRAC, DAY, MONTH, YEAR, ZH, ZM
`ifdef GPZDA_CHECKSUM_EN
        , CS_HI, CS_LO
`endif
    } state_t;

    state_t            state, state_d;
    logic [2:0]        cnt;
    logic              neg;
    logic [6:0]        p_hour, p_min, p_sec, p_day, p_mon;
    logic [YEAR_W-1:0] p_year;
    logic              take, take_neg, err_d, ok_d;

    wire       is_dig = (bus.data >= "0") && (bus.data <= "9");
    wire [3:0] dig    = bus.data[3:0];

`ifdef GPZDA_CHECKSUM_EN
    logic [7:0] cs;
    logic [3:0] cs_hi;
    wire        is_hex = is_dig || ((bus.data >= "A") && (bus.data <= "F"));
    wire [3:0]  hexv   = is_dig ? dig : dig + 4'd9;
`endif

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) state <= IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        take     = 1'b0;
        take_neg = 1'b0;
        err_d    = 1'b0;
        ok_d     = 1'b0;
        if (bus.load) begin
            if (bus.start) begin
                state_d = SEP;
            end else begin
                case (state)
                    IDLE: ;
                    SEP: if (bus.data == ",") state_d = TIME; else err_d = 1'b1;
                    TIME:
                        if (is_dig && cnt < 3'd6) take = 1'b1;
                        else if (cnt == 3'd6 && (bus.data == "," || bus.data == ".")) begin
                            if (p_hour > 7'd23 || p_min > 7'd59 || p_sec > 7'd60) err_d = 1'b1;
                            else state_d = (bus.data == ",") ? DAY : FRAC;
                        end else err_d = 1'b1;
                    FRAC:
                        if (bus.data == ",") state_d = DAY;
                        else if (!is_dig) err_d = 1'b1;
                    DAY:
                        if (is_dig && cnt < 3'd2) take = 1'b1;
                        else if (cnt == 3'd2 && bus.data == ",") begin
                            if (p_day == 7'd0 || p_day > 7'd31) err_d = 1'b1;
                            else state_d = MONTH;
                        end else err_d = 1'b1;
                    MONTH:
                        if (is_dig && cnt < 3'd2) take = 1'b1;
                        else if (cnt == 3'd2 && bus.data == ",") begin
                            if (p_mon == 7'd0 || p_mon > 7'd12) err_d = 1'b1;
                            else state_d = YEAR;
                        end else err_d = 1'b1;
                    YEAR:
                        if (is_dig && cnt < 3'd4) take = 1'b1;
                        else if (cnt == 3'd4 && bus.data == ",") state_d = ZH;
                        else err_d = 1'b1;
                    ZH:
                        if (bus.data == "-" && cnt == 3'd0 && !neg) take_neg = 1'b1;
                        else if (is_dig && cnt < 3'd2) take = 1'b1;
                        else if (cnt == 3'd2 && bus.data == ",") state_d = ZM;
                        else err_d = 1'b1;
                    ZM:
                        if (is_dig && cnt < 3'd2) take = 1'b1;
                        else if (cnt == 3'd2 && bus.data == "*") begin
`ifdef GPZDA_CHECKSUM_EN
                            state_d = CS_HI;
`else
                            ok_d = 1'b1;
`endif
                        end else err_d = 1'b1;
`ifdef GPZDA_CHECKSUM_EN
                    CS_HI: if (is_hex) state_d = CS_LO; else err_d = 1'b1;
                    CS_LO:
                        if (is_hex && {cs_hi, hexv} == cs) ok_d = 1'b1;
                        else err_d = 1'b1;
`endif
                    default: err_d = 1'b1;
                endcase
                if (err_d || ok_d) state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            cnt <= '0; neg <= 1'b0;
            p_hour <= '0; p_min <= '0; p_sec <= '0; p_day <= '0; p_mon <= '0; p_year <= '0;
            bus.hour <= '0; bus.minute <= '0; bus.second <= '0;
            bus.day <= '0; bus.month <= '0; bus.year <= '0;
            bus.valid <= 1'b0; bus.error <= 1'b0;
        end else begin
            bus.valid <= ok_d;
            bus.error <= err_d;
            if (bus.load) begin
                if (bus.start) begin
                    cnt <= '0; neg <= 1'b0;
                    p_hour <= '0; p_min <= '0; p_sec <= '0; p_day <= '0; p_mon <= '0; p_year <= '0;
                end else begin
                    if (state_d != state) cnt <= '0;
                    else if (take)        cnt <= cnt + 3'd1;
                    if (take_neg) neg <= 1'b1;
                    // TIME packs hh, mm, ss back to back; cnt picks the field
                    if (take) begin
                        case (state)
                            TIME:
                                if (cnt < 3'd2)      p_hour <= p_hour * 7'd10 + {3'b000, dig};
                                else if (cnt < 3'd4) p_min  <= p_min  * 7'd10 + {3'b000, dig};
                                else                 p_sec  <= p_sec  * 7'd10 + {3'b000, dig};
                            DAY:     p_day  <= p_day * 7'd10 + {3'b000, dig};
                            MONTH:   p_mon  <= p_mon * 7'd10 + {3'b000, dig};
                            YEAR:    p_year <= p_year * YEAR_W'(10) + YEAR_W'(dig);
                            default: ;
                        endcase
                    end
                end
            end
            if (ok_d) begin
                bus.hour <= p_hour[4:0]; bus.minute <= p_min[5:0]; bus.second <= p_sec[5:0];
                bus.day  <= p_day[4:0];  bus.month  <= p_mon[3:0]; bus.year   <= p_year;
            end
        end
    end

`ifdef GPZDA_CHECKSUM_EN
    // Seed is G^P^Z^D^A since the header bytes never reach this block
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            cs    <= 8'h48;
            cs_hi <= '0;
        end else if (bus.load) begin
            if (bus.start) cs <= 8'h48;
            else if (state != IDLE && state != CS_HI && state != CS_LO && bus.data != "*")
                cs <= cs ^ bus.data;
            if (state == CS_HI) cs_hi <= hexv;
        end
    end
`endif

    assign bus.busy = (state != IDLE);
endmodule
